div_result_buffer: RTL

DIV_RESULT_BUFFER -- requirements
Module: div_result_buffer

---
 rtl/div_result_buffer_if.sv | 29 ++
 rtl/div_result_buffer.sv | 91 +++++++++
 2 files changed

// File: rtl/div_result_buffer_if.sv
// Handshake bundle between the divider/issue logic, the result buffer and the consumer.
//   master: issue side + consumer (drives div_issue, div_valid, div_result, out_ready)
//   slave : the result buffer (drives issue_ok, out_valid, out_data, count, err)
interface div_result_buffer_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             div_issue;
  logic             div_valid;
  logic [WIDTH-1:0] div_result;
  logic             issue_ok;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             err;

  modport master (
    output div_issue, div_valid, div_result, out_ready,
    input  issue_ok, out_valid, out_data, count, err
  );

  modport slave (
    input  div_issue, div_valid, div_result, out_ready,
    output issue_ok, out_valid, out_data, count, err
  );
endinterface

// File: rtl/div_result_buffer.sv
// Credit-managed result FIFO behind a divider that cannot be back-pressured.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave side of div_result_buffer_if (issue credit, divider results,
//           consumer valid/ready, occupancy count, sticky error)
module div_result_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  div_result_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             err_q, err_d;
  logic             issue_ok_q, issue_ok_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             push_c;
  logic             pop_c;
  logic [SW-1:0]    credit_c;

  // Next-state: FIFO bookkeeping, in-flight credit tracking, protocol errors
  always_comb begin
    pop_c       = out_valid_q && bus.out_ready;
    // A full FIFO can still accept a result when the head leaves in the same cycle
    push_c      = bus.div_valid && ((count_q < CW'(DEPTH)) || pop_c);

    wr_ptr_d    = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push_c) - CW'(pop_c);

    inflight_d  = inflight_q;
    if (bus.div_issue && !bus.div_valid) begin
      if (inflight_q != CW'(DEPTH)) inflight_d = inflight_q + CW'(1);
    end else if (!bus.div_issue && bus.div_valid) begin
      if (inflight_q != CW'(0)) inflight_d = inflight_q - CW'(1);
    end

    err_d       = err_q
                | (bus.div_valid && (count_q == CW'(DEPTH)) && !pop_c)
                | (bus.div_issue && !issue_ok_q)
                | (bus.div_valid && (inflight_q == CW'(0)));

    // issue_ok is precomputed from next state so it is a pure flop output
    credit_c    = SW'(count_d) + SW'(inflight_d);
    issue_ok_d  = credit_c < SW'(DEPTH);
    out_valid_d = count_d != CW'(0);
  end

  // Control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      issue_ok_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      issue_ok_q  <= issue_ok_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Result storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.div_result;
  end

  assign bus.count     = count_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.issue_ok  = issue_ok_q;
  assign bus.err       = err_q;
endmodule
